booth_mult_seq: RTL

//  Sequential radix-2 Booth multiplier for the processor's multdiv path. Consumes the

---
 rtl/booth_mult_seq.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/booth_mult_seq.sv
// booth_mult_seq
//   Sequential radix-2 Booth multiplier. One add/subtract step per clock
//   through a carry-lookahead adder built from 8-bit slices. Produces the low
//   WIDTH bits of the signed product and a signed-overflow flag. A one-cycle
//   ready pulse marks a valid result.
//
// Ports
//   clock          : single clock, rising edge
//   reset          : synchronous, active-high, clears all state
//   ctrl_MULT      : start pulse; the operands are sampled on the same edge
//   data_operandA  : multiplicand M, two's complement
//   data_operandB  : multiplier Q, two's complement
//   data_result    : low WIDTH bits of A*B; held until the next completion
//   data_exception : the signed product does not fit in WIDTH bits
//   data_resultRDY : one-cycle pulse; data_result and data_exception are valid
//   busy           : high while the multiplier steps
module booth_mult_seq #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int NS = WIDTH / 8;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [CNTW-1:0] count;
  logic [WIDTH:0]  acc;     // one guard bit so that subtracting -2^(WIDTH-1) cannot wrap
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic            q_m1;

  // Booth recoding: 01 -> add M, 10 -> subtract M, 00/11 -> no change.
  logic             add_en;
  logic             sub;
  logic [WIDTH-1:0] b_op;
  logic             b_top;

  assign add_en = q[0] ^ q_m1;
  assign sub    = q[0] & ~q_m1;
  // Subtraction is acc + ~M + 1; the +1 enters as the adder carry-in.
  assign b_op   = add_en ? (sub ? ~m : m) : '0;
  assign b_top  = add_en ? (sub ? ~m[WIDTH-1] : m[WIDTH-1]) : 1'b0;

  // 8-bit carry-lookahead slice: returns {carry_out, sum}.
  function automatic logic [8:0] cla8(input logic [7:0] a, input logic [7:0] b, input logic ci);
    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = ci;
    for (int i = 0; i < 8; i++) c[i+1] = g[i] | (p[i] & c[i]);
    return {c[8], p ^ c[7:0]};
  endfunction

  logic [NS-1:0]   slice_g;
  logic [NS-1:0]   slice_p;
  logic [NS:0]     slice_c;
  logic [WIDTH:0]  sum;

  // Per-slice group generate/propagate, then lookahead across slices.
  for (genvar gi = 0; gi < NS; gi++) begin : g_slice
    logic [8:0] gen0;
    logic [8:0] res;
    assign gen0         = cla8(acc[gi*8 +: 8], b_op[gi*8 +: 8], 1'b0);
    assign slice_g[gi]  = gen0[8];
    assign slice_p[gi]  = &(acc[gi*8 +: 8] ^ b_op[gi*8 +: 8]);
    assign res          = cla8(acc[gi*8 +: 8], b_op[gi*8 +: 8], slice_c[gi]);
    assign sum[gi*8 +: 8] = res[7:0];
  end

  always_comb begin
    slice_c    = '0;
    slice_c[0] = sub;
    for (int s = 0; s < NS; s++) slice_c[s+1] = slice_g[s] | (slice_p[s] & slice_c[s]);
  end

  // Guard bit: the sign-extension position of the adder.
  assign sum[WIDTH] = acc[WIDTH] ^ b_top ^ slice_c[NS];

  // Arithmetic right shift of {sum, q, q_m1}.
  logic [WIDTH:0]   acc_sh;
  logic [WIDTH-1:0] q_sh;
  assign acc_sh = {sum[WIDTH], sum[WIDTH:1]};
  assign q_sh   = {sum[0], q[WIDTH-1:1]};

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      count          <= '0;
      acc            <= '0;
      q              <= '0;
      m              <= '0;
      q_m1           <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_MULT) begin
        // A start is honoured in every state; a running operation is abandoned.
        m     <= data_operandA;
        q     <= data_operandB;
        q_m1  <= 1'b0;
        acc   <= '0;
        count <= '0;
        state <= RUN;
        busy  <= 1'b1;
      end else begin
        case (state)
          RUN: begin
            acc   <= acc_sh;
            q     <= q_sh;
            q_m1  <= q[0];
            count <= count + 1'b1;
            if (count == CNTW'(WIDTH - 1)) begin
              state          <= DONE;
              busy           <= 1'b0;
              data_resultRDY <= 1'b1;
              data_result    <= q_sh;
              // Overflow unless the upper half is pure sign extension of the low word.
              data_exception <= (acc_sh != {(WIDTH+1){q_sh[WIDTH-1]}});
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
